true_dp_ram_be: RTL and testbench

- Next-generation true dual-port RAM for shared buffers between control cores and the acquisition/DMA paths.
- Generalised in width and depth. Adds:
  - per-byte write enables
  - port enables
  - selectable read-during-write mode
  - optional output pipeline register
  - same-address write collision flag
  - self-timed hardware clear sequencer
- Both ports share one clock domain.

---
 rtl/true_dp_ram_be.sv | 174 +++++++++++++++++
 tb/tb_true_dp_ram_be.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/true_dp_ram_be.sv
// True dual-port RAM with per-lane write enables, configurable read-during-write
// behaviour, optional output register, collision flag and a self-timed clear sequencer.
module true_dp_ram_be #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 8,
   parameter int                    BYTE_WIDTH  = 8,
   parameter int                    RDW_MODE    = 1,
   parameter int                    OUTPUT_REG  = 0,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                en_a,
   input  logic                                we_a,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    be_a,
   input  logic [ADDR_WIDTH-1:0]               addr_a,
   input  logic [DATA_WIDTH-1:0]               data_a_w,
   output logic [DATA_WIDTH-1:0]               data_a_r,
   input  logic                                en_b,
   input  logic                                we_b,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    be_b,
   input  logic [ADDR_WIDTH-1:0]               addr_b,
   input  logic [DATA_WIDTH-1:0]               data_b_w,
   output logic [DATA_WIDTH-1:0]               data_b_r,
   input  logic                                clear_start,
   output logic                                clear_busy,
   output logic                                collision
);

   localparam int N_LANES = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH   = 2 ** ADDR_WIDTH;
   localparam int RDW_NO_CHANGE   = 0;
   localparam int RDW_WRITE_FIRST = 2;
   localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

   if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end
   if (RDW_MODE < 0 || RDW_MODE > 2) begin : g_bad_rdw
      $error("RDW_MODE must be 0, 1 or 2");
   end

   typedef enum logic {S_IDLE, S_CLEAR} clr_state_t;

   clr_state_t            state, state_nxt;
   logic [ADDR_WIDTH:0]   cnt, cnt_nxt;
   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;

   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: CLEAR_VALUE};

   logic [DATA_WIDTH-1:0] old_a, old_b;
   logic [DATA_WIDTH-1:0] rd_a_p0, rd_b_p0;
   logic                  acc_a, acc_b, wr_a, wr_b, ld_a_p0, ld_b_p0;
   logic [DATA_WIDTH-1:0] rd_a_p1, rd_b_p1;

   function automatic logic [DATA_WIDTH-1:0] merge_lanes(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [N_LANES-1:0]    lanes
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_word;
      for (int i = 0; i < N_LANES; i++) begin
         if (lanes[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      return res;
   endfunction

   // Stage p0: port qualification and the word each port would capture
   always_comb begin
      old_a   = mem[addr_a];
      old_b   = mem[addr_b];
      acc_a   = en_a && !clear_busy;
      acc_b   = en_b && !clear_busy;
      wr_a    = acc_a && we_a;
      wr_b    = acc_b && we_b;
      ld_a_p0 = acc_a && (!we_a || RDW_MODE != RDW_NO_CHANGE);
      ld_b_p0 = acc_b && (!we_b || RDW_MODE != RDW_NO_CHANGE);
      rd_a_p0 = (we_a && RDW_MODE == RDW_WRITE_FIRST) ? merge_lanes(old_a, data_a_w, be_a) : old_a;
      rd_b_p0 = (we_b && RDW_MODE == RDW_WRITE_FIRST) ? merge_lanes(old_b, data_b_w, be_b) : old_b;
   end

   // Port A is applied last so it owns lanes enabled on both ports
   always_ff @(posedge clock) begin
      if (clr_we) mem[clr_addr] <= CLEAR_VALUE;
      for (int i = 0; i < N_LANES; i++) begin
         if (wr_b && be_b[i])
            mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_b_w[i*BYTE_WIDTH +: BYTE_WIDTH];
         if (wr_a && be_a[i])
            mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_a_w[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   // Stage p1: first read register and collision flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_a_p1   <= '0;
         rd_b_p1   <= '0;
         collision <= 1'b0;
      end else begin
         if (ld_a_p0) rd_a_p1 <= rd_a_p0;
         if (ld_b_p0) rd_b_p1 <= rd_b_p0;
         collision <= wr_a && wr_b && (addr_a == addr_b);
      end
   end

   // Stage p2: optional output register, advancing only behind a fresh p1 load
   if (OUTPUT_REG != 0) begin : g_oreg
      logic                  vld_a_p1, vld_b_p1;
      logic [DATA_WIDTH-1:0] rd_a_p2, rd_b_p2;

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            vld_a_p1 <= 1'b0;
            vld_b_p1 <= 1'b0;
            rd_a_p2  <= '0;
            rd_b_p2  <= '0;
         end else begin
            vld_a_p1 <= ld_a_p0;
            vld_b_p1 <= ld_b_p0;
            if (vld_a_p1) rd_a_p2 <= rd_a_p1;
            if (vld_b_p1) rd_b_p2 <= rd_b_p1;
         end
      end

      assign data_a_r = rd_a_p2;
      assign data_b_r = rd_b_p2;
   end else begin : g_noreg
      assign data_a_r = rd_a_p1;
      assign data_b_r = rd_b_p1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // The extra counter bit keeps the terminal compare from aliasing address 0
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (clear_start) state_nxt = S_CLEAR;
         end
         S_CLEAR: begin
            if (cnt == CNT_LAST) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      clear_busy = (state == S_CLEAR);
      clr_we     = (state == S_CLEAR);
      clr_addr   = cnt[ADDR_WIDTH-1:0];
   end

endmodule

// File: tb/tb_true_dp_ram_be.sv
// Bench for true_dp_ram_be: three instances (NO_CHANGE, READ_FIRST, WRITE_FIRST with
// output register) share one stimulus stream and are checked against a word-level model.
module tb_true_dp_ram_be;

   localparam int          DW    = 32;
   localparam int          AW    = 4;
   localparam int          NL    = 4;
   localparam int          DEPTH = 16;
   localparam logic [31:0] CV    = 32'h5A5A_0000;

   logic          clock, reset, clear_start;
   logic          en_a, we_a, en_b, we_b;
   logic [NL-1:0] be_a, be_b;
   logic [AW-1:0] addr_a, addr_b;
   logic [DW-1:0] data_a_w, data_b_w;
   logic [DW-1:0] dr_a [3];
   logic [DW-1:0] dr_b [3];
   logic          busy [3];
   logic          coll [3];

   for (genvar k = 0; k < 3; k++) begin : g_dut
      true_dp_ram_be #(
         .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
         .RDW_MODE(k), .OUTPUT_REG(k == 2 ? 1 : 0), .CLEAR_VALUE(CV)
      ) u_dut (
         .clock(clock), .reset(reset),
         .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a),
         .data_a_w(data_a_w), .data_a_r(dr_a[k]),
         .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b),
         .data_b_w(data_b_w), .data_b_r(dr_b[k]),
         .clear_start(clear_start), .clear_busy(busy[k]), .collision(coll[k])
      );
   end

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] m_mem [DEPTH];
   logic [DW-1:0] m_s1 [3][2];
   logic [DW-1:0] m_s2 [3][2];
   bit            m_v  [3][2];
   bit            m_busy, m_coll;
   int            m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [NL-1:0] be);
      logic [DW-1:0] mask;
      mask = '0;
      for (int i = 0; i < NL; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
      return (old_w & ~mask) | (new_w & mask);
   endfunction

   function automatic logic [DW-1:0] pat(input int i);
      return 32'h0101_0101 * (i + 1);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++)
         for (int p = 0; p < 2; p++) begin
            m_s1[k][p] = '0; m_s2[k][p] = '0; m_v[k][p] = 0;
         end
      m_busy = 0; m_coll = 0; m_cnt = 0;
   endtask

   // One clock edge of the reference: reads see the pre-edge memory contents
   task automatic model_edge();
      logic [DW-1:0] old_w [2];
      logic [DW-1:0] new_w [2];
      logic [NL-1:0] be [2];
      bit            acc [2];
      bit            wr [2];
      if (reset) begin
         model_reset();
         return;
      end
      old_w[0] = m_mem[addr_a]; old_w[1] = m_mem[addr_b];
      new_w[0] = data_a_w;      new_w[1] = data_b_w;
      be[0]    = be_a;          be[1]    = be_b;
      acc[0]   = !m_busy && en_a;
      acc[1]   = !m_busy && en_b;
      wr[0]    = acc[0] && we_a;
      wr[1]    = acc[1] && we_b;
      for (int k = 0; k < 3; k++)
         for (int p = 0; p < 2; p++) begin
            if (k == 2 && m_v[k][p]) m_s2[k][p] = m_s1[k][p];
            m_v[k][p] = 0;
            if (acc[p] && !wr[p]) begin
               m_s1[k][p] = old_w[p]; m_v[k][p] = 1;
            end else if (wr[p] && k == 1) begin
               m_s1[k][p] = old_w[p]; m_v[k][p] = 1;
            end else if (wr[p] && k == 2) begin
               m_s1[k][p] = lane_merge(old_w[p], new_w[p], be[p]); m_v[k][p] = 1;
            end
         end
      if (wr[1]) m_mem[addr_b] = lane_merge(m_mem[addr_b], data_b_w, be_b);
      if (wr[0]) m_mem[addr_a] = lane_merge(m_mem[addr_a], data_a_w, be_a);
      m_coll = wr[0] && wr[1] && (addr_a == addr_b);
      if (m_busy) begin
         m_mem[m_cnt] = CV;
         if (m_cnt == DEPTH - 1) begin
            m_busy = 0; m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end else if (clear_start) begin
         m_busy = 1;
      end
   endtask

   task automatic check_model();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("dut%0d data_a_r", k), dr_a[k], (k == 2) ? m_s2[k][0] : m_s1[k][0]);
         chk($sformatf("dut%0d data_b_r", k), dr_b[k], (k == 2) ? m_s2[k][1] : m_s1[k][1]);
         chk($sformatf("dut%0d clear_busy", k), {31'b0, busy[k]}, {31'b0, m_busy});
         chk($sformatf("dut%0d collision", k), {31'b0, coll[k]}, {31'b0, m_coll});
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check_model();
   endtask

   task automatic idle();
      en_a = 0; we_a = 0; be_a = '0; addr_a = '0; data_a_w = '0;
      en_b = 0; we_b = 0; be_b = '0; addr_b = '0; data_b_w = '0;
      clear_start = 0;
   endtask

   task automatic write_a(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] be);
      idle(); en_a = 1; we_a = 1; addr_a = a; data_a_w = d; be_a = be;
      cycle();
   endtask

   task automatic read_chk(input logic [AW-1:0] a, input logic [DW-1:0] expv, input string tag);
      idle(); en_a = 1; addr_a = a; en_b = 1; addr_b = a;
      cycle();
      chk({tag, " nc_a"}, dr_a[0], expv);
      chk({tag, " rf_a"}, dr_a[1], expv);
      chk({tag, " rf_b"}, dr_b[1], expv);
      idle();
      cycle();
      chk({tag, " wf_reg_a"}, dr_a[2], expv);
   endtask

   task automatic run_clear(input string tag, input bit poke);
      int n;
      idle(); clear_start = 1;
      cycle();
      clear_start = 0;
      n = 0;
      while (busy[1] === 1'b1 && n < 64) begin
         idle();
         if (poke && n == 5) clear_start = 1;
         if (poke && n == 10) begin
            en_a = 1; we_a = 1; be_a = '1; addr_a = 4'd2; data_a_w = 32'h1234_5678;
         end
         cycle();
         n++;
      end
      idle();
      chk({tag, " busy_cycles"}, n, 16);
   endtask

   initial begin
      int guard;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = CV;
      model_reset();
      idle();
      reset = 1;
      cycle();
      cycle();
      chk("reset data_a_r", dr_a[1], 32'h0);
      chk("reset busy", {31'b0, busy[1]}, 32'h0);
      reset = 0;
      cycle();

      // Lane masking
      write_a(4'd5, 32'hAABB_CCDD, 4'b1111);
      idle(); en_b = 1; we_b = 1; addr_b = 4'd5; data_b_w = 32'h1122_3344; be_b = 4'b0101;
      cycle();
      read_chk(4'd5, 32'hAA22_CC44, "lane_mask");

      // Same-port read-during-write
      idle(); en_b = 1; we_b = 1; addr_b = 4'd3; data_b_w = 32'h0; be_b = 4'b1111;
      cycle();
      write_a(4'd3, 32'hDEAD_BEEF, 4'b1111);
      chk("rdw no_change", dr_a[0], 32'hAA22_CC44);
      chk("rdw read_first", dr_a[1], 32'h0000_0000);
      idle();
      cycle();
      chk("rdw write_first", dr_a[2], 32'hDEAD_BEEF);

      // Dual write collision
      idle();
      en_a = 1; we_a = 1; addr_a = 4'd7; data_a_w = 32'h0000_00FF; be_a = 4'b0011;
      en_b = 1; we_b = 1; addr_b = 4'd7; data_b_w = 32'hFFFF_0000; be_b = 4'b1110;
      cycle();
      chk("collision pulse", {31'b0, coll[1]}, 32'h1);
      idle();
      cycle();
      chk("collision drop", {31'b0, coll[1]}, 32'h0);
      read_chk(4'd7, 32'hFFFF_00FF, "collision_word");
      idle();
      en_a = 1; we_a = 1; addr_a = 4'd9; data_a_w = 32'h0000_0011; be_a = 4'b0001;
      en_b = 1; we_b = 1; addr_b = 4'd9; data_b_w = 32'h0000_2200; be_b = 4'b0010;
      cycle();
      chk("collision disjoint", {31'b0, coll[1]}, 32'h1);

      // Enable hold
      write_a(4'd2, 32'h0000_0055, 4'b1111);
      read_chk(4'd2, 32'h0000_0055, "hold_setup");
      for (int i = 0; i < 4; i++) begin
         idle(); we_a = 1; be_a = '1; addr_a = 4'(i + 8); data_a_w = $urandom;
         cycle();
         chk("enable hold rf", dr_a[1], 32'h0000_0055);
         chk("enable hold wf_reg", dr_a[2], 32'h0000_0055);
      end

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         idle();
         en_a = ($urandom_range(3) != 0); we_a = $urandom_range(1);
         be_a = 4'($urandom); addr_a = 4'($urandom); data_a_w = $urandom;
         en_b = ($urandom_range(3) != 0); we_b = $urandom_range(1);
         be_b = 4'($urandom); data_b_w = $urandom;
         addr_b = ($urandom_range(3) == 0) ? addr_a : 4'($urandom);
         clear_start = ($urandom_range(59) == 0);
         cycle();
      end
      idle();
      guard = 0;
      while (m_busy && guard < 40) begin
         cycle();
         guard++;
      end

      // Full clear with a dropped write and an ignored restart
      for (int i = 0; i < DEPTH; i++) write_a(4'(i), pat(i), 4'b1111);
      run_clear("clear", 1);
      for (int i = 0; i < DEPTH; i++) read_chk(4'(i), CV, $sformatf("cleared[%0d]", i));

      // Reset in the middle of a clear
      for (int i = 0; i < DEPTH; i++) write_a(4'(i), pat(i), 4'b1111);
      idle(); clear_start = 1;
      cycle();
      idle();
      guard = 0;
      while (m_cnt != 8 && guard < 40) begin
         cycle();
         guard++;
      end
      chk("mid clear reached", guard, 8);
      reset = 1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("async busy dut%0d", k), {31'b0, busy[k]}, 32'h0);
         chk($sformatf("async data_a_r dut%0d", k), dr_a[k], 32'h0);
         chk($sformatf("async data_b_r dut%0d", k), dr_b[k], 32'h0);
      end
      model_reset();
      cycle();
      reset = 0;
      cycle();
      for (int i = 0; i < DEPTH; i++)
         read_chk(4'(i), (i < 8) ? CV : pat(i), $sformatf("partial[%0d]", i));
      run_clear("reclear", 0);
      for (int i = 0; i < DEPTH; i++) read_chk(4'(i), CV, $sformatf("recleared[%0d]", i));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
